sram_mem_ctrl: RTL and testbench
================================

// Module: sram_mem_ctrl
// PURPOSE
//  Responder for the core's instruction (rom_*) and data (ram_*) ports; both share one external async 32-bit SRAM.
//  Arbitrates fetch vs. data access, sequences SRAM write strobes, and raises stall requests to ctrl.
//  Sits at top level between the openmips core and the SRAM pins.
// PARAMETERS
//  ADDR_W           20  SRAM word-address width; byte address bits [ADDR_W+1:2] select the word.
//  DATA_W           32  SRAM/bus data width.
//  WR_PULSE_CYCLES  1   cycles sram_we_n is held low per store; legal range 1..15.
// PORTS
//  clk          in   1       core clock
//  rst          in   1       synchronous, active-low reset
//  rom_ce_i     in   1       fetch enable from core
//  rom_addr_i   in   32      fetch byte address
//  rom_data_o   out  32      fetched instruction; 32'h0 (NOP) when not served
//  ram_ce_i     in   1       data access enable
//  ram_we_i     in   1       1 = store, 0 = load
//  ram_addr_i   in   32      data byte address
//  ram_data_i   in   32      store data
//  ram_data_o   out  32      load data; 32'h0 when no load is served
//  stall_fetch_o out 1       hold PC, IF/ID
//  stall_mem_o  out  1       hold PC through EX/MEM; MEM instruction stays put
//  sram_addr    out  ADDR_W  SRAM word address
//  sram_data    inout DATA_W SRAM data bus
//  sram_ce_n    out  1       chip enable, low active
//  sram_oe_n    out  1       output enable, low active
//  sram_we_n    out  1       write enable, low active
//  sram_be_n    out  4       byte enables; always 4'b0000 (word access only)
// BEHAVIOUR
//  - FSM states: IDLE, WR_PULSE, WR_HOLD. Pulse counter is 4 bits.
//  - Reset (rst==0 at a clk edge): state=IDLE, counter=0. While the FSM is in IDLE with no access, outputs are
//    sram_we_n=1, sram_oe_n=0, sram_data released (Z), stall_*=0, and rom_data_o/ram_data_o=0 if rom_ce_i=0.
//  - IDLE, ram_ce_i=0: sram_addr=rom_addr_i[ADDR_W+1:2], oe_n=0.
//    rom_data_o=sram_data combinationally, with zero-cycle latency. If rom_ce_i=0, rom_data_o=0.
//  - IDLE, load (ram_ce_i=1, ram_we_i=0): data wins. sram_addr=ram_addr_i word, oe_n=0, ram_data_o=sram_data.
//    rom_data_o=0 and stall_fetch_o=1 for exactly this cycle. State stays IDLE.
//  - IDLE, store (ram_ce_i=1, ram_we_i=1): this is the setup cycle.
//    Drive sram_addr=ram_addr_i word and sram_data=ram_data_i. Set oe_n=1, we_n=1, stall_mem_o=1, stall_fetch_o=1.
//    Next state is WR_PULSE with counter=WR_PULSE_CYCLES-1.
//  - WR_PULSE: addr and data held from registered copies captured in the setup cycle. we_n=0, oe_n=1, both stalls=1.
//    Counter decrements; go to WR_HOLD when counter==0.
//  - WR_HOLD: we_n=1, addr/data still driven (hold time), stall_mem_o=0, stall_fetch_o=1, rom_data_o=0.
//    Always go to IDLE; ram_ce_i/ram_we_i are ignored in this cycle, so the same store never restarts.
//  - Store occupancy = 2 + WR_PULSE_CYCLES cycles. Back-to-back stores: second setup starts in the IDLE cycle after WR_HOLD.
//  - Data is driven onto sram_data only in the setup, WR_PULSE and WR_HOLD cycles; it is Z otherwise.
//  - sram_ce_n=0 whenever rom_ce_i or ram_ce_i is 1, or the state is not IDLE; otherwise 1.
//  - Reset mid-write: the next edge with rst=0 forces IDLE. we_n rises and the bus is released in the same cycle. The store is lost.
//  - Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the SRAM size. Bits [1:0] are ignored.
// STRUCTURE
//  - Add state encodings, the NOP constant (32'h0) and SRAM widths to the shared defines file.
//  - One sub-module, sram_pad: the bidirectional tristate buffer (oe, dout, din) for sram_data.
// TESTING
//  - Fetch: SRAM[0x10]=0x3C010001, rom_addr_i=0x40 -> rom_data_o=0x3C010001 same cycle, stalls 0.
//  - Load during fetch: ram_addr_i=0x100, SRAM[0x40]=0xDEADBEEF -> ram_data_o=0xDEADBEEF, rom_data_o=0, stall_fetch_o=1 for 1 cycle.
//  - Store, WR_PULSE_CYCLES=1: 0x12345678 to 0x200 -> we_n low exactly 1 cycle, stall_mem_o high 2 cycles, stall_fetch_o high 3 cycles,
//    then read of 0x200 returns 0x12345678.
//  - Back-to-back stores to 0x0 and 0x4 -> two distinct we_n pulses with we_n=1 between them; both words read back correctly.
//  - Reset during WR_PULSE -> next cycle state IDLE, we_n=1, sram_data=Z, stalls 0.
//  - Address wrap: load from 0x0040_0000 with ADDR_W=20 -> sram_addr=0, returns SRAM[0].

Source files
------------

// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the SRAM memory controller: FSM states, bus widths, NOP word.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_PULSE = 2'd1,
    ST_WR_HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] NOP         = 32'h0;
  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SRAM_BE_W   = 4;
  localparam int unsigned PULSE_CNT_W = 4;

endpackage

// File: rtl/sram_mem_ctrl_pad.sv
// Bidirectional tristate buffer for the shared SRAM data bus.
module sram_pad #(
  parameter int unsigned W = 32
) (
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  assign pad = oe ? dout : 'z;
  assign din = pad;

endmodule

// File: rtl/sram_mem_ctrl.sv
// Shares one async SRAM between instruction fetch and data access; data wins, stores run a
// setup / write-pulse / hold sequence while the core is stalled.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W          = SRAM_ADDR_W,
  parameter int unsigned DATA_W          = SRAM_DATA_W,
  parameter int unsigned WR_PULSE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rom_ce_i,
  input  logic [31:0]          rom_addr_i,
  output logic [DATA_W-1:0]    rom_data_o,
  input  logic                 ram_ce_i,
  input  logic                 ram_we_i,
  input  logic [31:0]          ram_addr_i,
  input  logic [DATA_W-1:0]    ram_data_i,
  output logic [DATA_W-1:0]    ram_data_o,
  output logic                 stall_fetch_o,
  output logic                 stall_mem_o,
  output logic [ADDR_W-1:0]    sram_addr,
  inout  wire  [DATA_W-1:0]    sram_data,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [SRAM_BE_W-1:0] sram_be_n
);

  localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD = PULSE_CNT_W'(WR_PULSE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [PULSE_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    bus_oe;
  logic [DATA_W-1:0]       bus_dout;
  logic [DATA_W-1:0]       bus_din;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0],
                              ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0]};

  sram_pad #(.W(DATA_W)) u_pad (
    .oe   (bus_oe),
    .dout (bus_dout),
    .din  (bus_din),
    .pad  (sram_data)
  );

  assign sram_be_n = '0;
  assign sram_ce_n = !(rom_ce_i || ram_ce_i || (state_q != ST_IDLE));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    sram_addr     = rom_addr_i[ADDR_W+1:2];
    sram_oe_n     = 1'b0;
    sram_we_n     = 1'b1;
    bus_oe        = 1'b0;
    bus_dout      = data_q;
    stall_fetch_o = 1'b0;
    stall_mem_o   = 1'b0;
    rom_data_o    = rom_ce_i ? bus_din : DATA_W'(NOP);
    ram_data_o    = DATA_W'(NOP);
    case (state_q)
      ST_IDLE: begin
        if (ram_ce_i) begin
          sram_addr     = ram_addr_i[ADDR_W+1:2];
          rom_data_o    = DATA_W'(NOP);
          stall_fetch_o = 1'b1;
          if (ram_we_i) begin
            // Setup cycle drives the live inputs; later phases replay the captured copies.
            sram_oe_n   = 1'b1;
            bus_oe      = 1'b1;
            bus_dout    = ram_data_i;
            stall_mem_o = 1'b1;
            addr_d      = ram_addr_i[ADDR_W+1:2];
            data_d      = ram_data_i;
            cnt_d       = PULSE_LOAD;
            state_d     = ST_WR_PULSE;
          end else begin
            ram_data_o  = bus_din;
          end
        end
      end
      ST_WR_PULSE: begin
        sram_addr     = addr_q;
        sram_oe_n     = 1'b1;
        sram_we_n     = 1'b0;
        bus_oe        = 1'b1;
        stall_fetch_o = 1'b1;
        stall_mem_o   = 1'b1;
        rom_data_o    = DATA_W'(NOP);
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_HOLD: begin
        sram_addr     = addr_q;
        sram_oe_n     = 1'b1;
        bus_oe        = 1'b1;
        stall_fetch_o = 1'b1;
        rom_data_o    = DATA_W'(NOP);
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_sram_mem_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned P  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i, ram_ce_i, ram_we_i;
  logic [31:0] rom_addr_i, ram_addr_i, ram_data_i;
  logic [31:0] rom_data_o, ram_data_o;
  logic        stall_fetch_o, stall_mem_o;
  logic [AW-1:0] sram_addr;
  wire  [31:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  int ncheck = 0;
  int nerr   = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl #(.ADDR_W(AW), .DATA_W(32), .WR_PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_addr_i(ram_addr_i),
    .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
    .stall_fetch_o(stall_fetch_o), .stall_mem_o(stall_mem_o),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // Async SRAM device model
  logic [31:0] sram_mem [0:(1<<AW)-1];
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 'z;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_data;

  // Reference: word-addressed memory contents as the core should see them
  logic [31:0] ref_mem [int unsigned];

  typedef struct {
    string       tag;
    logic [31:0] rom, ram, bus;
    logic        sf, sm, we_n, oe_n, ce_n, chk_bus;
    logic [19:0] addr;
  } exp_t;
  exp_t exp_q[$];

  function automatic void chk(string t, string f, logic [31:0] act, logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s.%s: got %h expected %h", t, f, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "rom_data_o", rom_data_o, e.rom);
      chk(e.tag, "ram_data_o", ram_data_o, e.ram);
      chk(e.tag, "stall_fetch_o", 32'(stall_fetch_o), 32'(e.sf));
      chk(e.tag, "stall_mem_o", 32'(stall_mem_o), 32'(e.sm));
      chk(e.tag, "sram_we_n", 32'(sram_we_n), 32'(e.we_n));
      chk(e.tag, "sram_oe_n", 32'(sram_oe_n), 32'(e.oe_n));
      chk(e.tag, "sram_ce_n", 32'(sram_ce_n), 32'(e.ce_n));
      chk(e.tag, "sram_be_n", 32'(sram_be_n), 32'h0);
      chk(e.tag, "sram_addr", 32'(sram_addr), 32'(e.addr));
      if (e.chk_bus) chk(e.tag, "sram_data", sram_data, e.bus);
    end
  end

  function automatic logic [19:0] wd(logic [31:0] a);
    return a[21:2];
  endfunction

  function automatic exp_t idle_exp(string t, logic [19:0] a);
    exp_t e;
    e.tag = t; e.rom = '0; e.ram = '0; e.bus = '0;
    e.sf = 1'b0; e.sm = 1'b0; e.we_n = 1'b1; e.oe_n = 1'b0; e.ce_n = 1'b1;
    e.chk_bus = 1'b0; e.addr = a;
    return e;
  endfunction

  // Random byte address in a 256-word window with random high (wrapping) and low bits
  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = $urandom;
    a[21:2] = 20'($urandom_range(0, 255));
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rce, logic [31:0] ra, logic mce, logic mwe, logic [31:0] ma, logic [31:0] md);
    rom_ce_i = rce; rom_addr_i = ra;
    ram_ce_i = mce; ram_we_i = mwe; ram_addr_i = ma; ram_data_i = md;
  endtask

  task automatic set_word(logic [19:0] w, logic [31:0] v);
    sram_mem[w] = v;
    ref_mem[32'(w)] = v;
  endtask

  task automatic fetch(string t, logic rce, logic [31:0] ra);
    exp_t e;
    drive(rce, ra, 1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom);
    e = idle_exp(t, wd(ra));
    if (rce) begin
      e.rom = ref_mem[32'(wd(ra))]; e.ce_n = 1'b0;
      e.chk_bus = 1'b1; e.bus = e.rom;
    end
    exp_q.push_back(e);
    step();
  endtask

  task automatic load(string t, logic rce, logic [31:0] ra, logic [31:0] ma);
    exp_t e;
    drive(rce, ra, 1'b1, 1'b0, ma, $urandom);
    e = idle_exp(t, wd(ma));
    e.ram = ref_mem[32'(wd(ma))]; e.sf = 1'b1; e.ce_n = 1'b0;
    e.chk_bus = 1'b1; e.bus = e.ram;
    exp_q.push_back(e);
    step();
  endtask

  // Store occupies setup + P pulse cycles + hold; inputs stay asserted throughout, as a stalled core would.
  task automatic store(string t, logic rce, logic [31:0] ra, logic [31:0] ma, logic [31:0] md);
    exp_t e;
    drive(rce, ra, 1'b1, 1'b1, ma, md);
    e = idle_exp(t, wd(ma));
    e.sf = 1'b1; e.sm = 1'b1; e.oe_n = 1'b1; e.ce_n = 1'b0; e.chk_bus = 1'b1; e.bus = md;
    exp_q.push_back(e);
    step();
    e.we_n = 1'b0;
    for (int unsigned i = 0; i < P; i++) begin
      exp_q.push_back(e);
      step();
    end
    e.we_n = 1'b1; e.sm = 1'b0;
    exp_q.push_back(e);
    step();
    ref_mem[32'(wd(ma))] = md;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [31:0] ra;
    int unsigned r;
    for (int unsigned i = 0; i < 256; i++) set_word(20'(i), $urandom);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    ra = raddr();
    drive(1'b0, ra, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(idle_exp("reset", wd(ra)));
    step();
    rst = 1'b1;

    set_word(20'h10, 32'h3C01_0001);
    fetch("fetch_0x40", 1'b1, 32'h0000_0040);
    set_word(20'h40, 32'hDEAD_BEEF);
    load("load_0x100", 1'b1, 32'h0000_0040, 32'h0000_0100);
    fetch("fetch_after_load", 1'b1, 32'h0000_0040);
    store("store_0x200", 1'b1, 32'h0000_0044, 32'h0000_0200, 32'h1234_5678);
    load("readback_0x200", 1'b0, 32'h0, 32'h0000_0200);
    store("b2b_0x0", 1'b1, 32'h0000_0008, 32'h0000_0000, 32'hA5A5_0000);
    store("b2b_0x4", 1'b1, 32'h0000_0008, 32'h0000_0004, 32'h5A5A_0004);
    load("readback_0x0", 1'b1, 32'h0000_0008, 32'h0000_0000);
    load("readback_0x4", 1'b1, 32'h0000_0008, 32'h0000_0004);
    load("wrap_0x400000", 1'b1, 32'h0000_0008, 32'h0040_0000);
    fetch("fetch_wrap", 1'b1, 32'hFFC0_0043);
    fetch("fetch_off", 1'b0, 32'h0000_0040);

    // Reset asserted during the write pulse
    drive(1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D);
    e = idle_exp("rst_wr_setup", 20'hC0);
    e.sf = 1'b1; e.sm = 1'b1; e.oe_n = 1'b1; e.ce_n = 1'b0; e.chk_bus = 1'b1; e.bus = 32'hCAFE_F00D;
    exp_q.push_back(e);
    step();
    rst = 1'b0;
    e.tag = "rst_wr_pulse"; e.we_n = 1'b0;
    exp_q.push_back(e);
    step();
    rst = 1'b1;
    drive(1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0300, 32'hCAFE_F00D);
    exp_q.push_back(idle_exp("rst_after", 20'h10));
    step();
    fetch("rst_bus_free", 1'b1, 32'h0000_0040);
    set_word(20'hC0, 32'h0BAD_0BAD);

    for (int unsigned n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      fetch("rnd_fetch", $urandom_range(0, 7) != 0, raddr());
      else if (r < 7) load("rnd_load", $urandom_range(0, 1) == 1, raddr(), raddr());
      else            store("rnd_store", $urandom_range(0, 1) == 1, raddr(), raddr(), $urandom);
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("end", "pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
    $finish;
  end

endmodule
